// File: rtl/mem_arbiter_if.sv
// Requester and RAM bus bundle for mem_arbiter; per-port fields are packed port-major.
interface mem_arbiter_if #(
  parameter int N_PORTS    = 2,
  parameter int ADDR_WIDTH = 32
);
  logic [N_PORTS-1:0]            req_in;
  logic [N_PORTS-1:0]            wr_in;
  logic [2*N_PORTS-1:0]          len_in;
  logic [ADDR_WIDTH*N_PORTS-1:0] addr_in;
  logic [32*N_PORTS-1:0]         wdata_in;
  logic [N_PORTS-1:0]            grant_out;
  logic [N_PORTS-1:0]            done_out;
  logic [N_PORTS-1:0]            err_out;
  logic [31:0]                   rdata_out;
  logic [ADDR_WIDTH-1:0]         mem_a;
  logic [7:0]                    mem_dout;
  logic                          mem_wr;
  logic [7:0]                    mem_din;

  modport slave (
    input  req_in, wr_in, len_in, addr_in, wdata_in, mem_din,
    output grant_out, done_out, err_out, rdata_out, mem_a, mem_dout, mem_wr
  );

  modport master (
    output req_in, wr_in, len_in, addr_in, wdata_in, mem_din,
    input  grant_out, done_out, err_out, rdata_out, mem_a, mem_dout, mem_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin N-port arbiter sequencing byte/half/word accesses onto an 8-bit RAM bus.
// Define MEM_ARB_MISALIGN_EN to sequence misaligned half/word accesses instead of rejecting them.
module mem_arbiter #(
  parameter int N_PORTS    = 2,
  parameter int ADDR_WIDTH = 32
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  mem_arbiter_if.slave bus
);
  localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                state, state_nxt;
  logic [PTR_W-1:0]      rr_ptr, sel, cand;
  logic                  any_req;
  logic [N_PORTS-1:0]    grant_q;
  logic                  wr_q, err_q, issued_q;
  logic [1:0]            len_q, cnt, idx_q, last_idx;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q, rdata_q;
  logic                  sel_wr, reject;
  logic [1:0]            sel_len;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [31:0]           sel_wdata;

  // First requesting port at or after rr_ptr; scanning downward lets the nearest one win.
  always_comb begin
    any_req = 1'b0;
    sel     = '0;
    cand    = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      cand = PTR_W'((int'(rr_ptr) + i) % N_PORTS);
      if (bus.req_in[cand]) begin
        any_req = 1'b1;
        sel     = cand;
      end
    end
  end

  assign sel_wr    = bus.wr_in[sel];
  assign sel_len   = bus.len_in[2*int'(sel) +: 2];
  assign sel_addr  = bus.addr_in[ADDR_WIDTH*int'(sel) +: ADDR_WIDTH];
  assign sel_wdata = bus.wdata_in[32*int'(sel) +: 32];

`ifdef MEM_ARB_MISALIGN_EN
  assign reject = 1'b0;
`else
  assign reject = ((sel_len == 2'b01) && sel_addr[0]) ||
                  (sel_len[1] && (sel_addr[1:0] != 2'b00));
`endif

  always_comb begin
    case (len_q)
      2'b00:   last_idx = 2'd0;
      2'b01:   last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (rdy_in) begin
      case (state)
        IDLE:    if (any_req) state_nxt = reject ? DONE : ISSUE;
        ISSUE:   if (cnt == last_idx) state_nxt = wr_q ? DONE : DRAIN;
        DRAIN:   state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rr_ptr   <= '0;
      grant_q  <= '0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      len_q    <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt      <= 2'd0;
      issued_q <= 1'b0;
      idx_q    <= 2'd0;
      rdata_q  <= '0;
    end else begin
      issued_q <= rdy_in && (state == ISSUE) && !wr_q;
      idx_q    <= cnt;
      // The byte issued in the last active cycle arrives regardless of a stall starting now.
      if (issued_q) rdata_q[8*idx_q +: 8] <= bus.mem_din;
      if (rdy_in) begin
        case (state)
          IDLE: if (any_req) begin
            grant_q <= N_PORTS'(1) << sel;
            wr_q    <= sel_wr;
            len_q   <= sel_len;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            err_q   <= reject;
            cnt     <= 2'd0;
            rdata_q <= '0;
            rr_ptr  <= PTR_W'((int'(sel) + 1) % N_PORTS);
          end
          ISSUE: cnt <= cnt + 2'd1;
          DONE: begin
            grant_q <= '0;
            err_q   <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.grant_out = grant_q;
  assign bus.done_out  = ((state == DONE) && rdy_in && !err_q) ? grant_q : '0;
`ifdef MEM_ARB_MISALIGN_EN
  assign bus.err_out   = '0;
`else
  assign bus.err_out   = ((state == DONE) && rdy_in && err_q) ? grant_q : '0;
`endif
  assign bus.rdata_out = (state == DONE) ? rdata_q : '0;
  assign bus.mem_a     = addr_q + ADDR_WIDTH'(cnt);
  assign bus.mem_dout  = (state == ISSUE) ? wdata_q[8*cnt +: 8] : 8'h00;
  assign bus.mem_wr    = (state == ISSUE) && wr_q && rdy_in;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a registered-read RAM model, expected completions and write bytes queued at drive time.
module tb_mem_arbiter;
  localparam int NP = 2;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic rdy;

  mem_arbiter_if #(.N_PORTS(NP), .ADDR_WIDTH(AW)) bus ();

  mem_arbiter #(.N_PORTS(NP), .ADDR_WIDTH(AW)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .rdy_in (rdy),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:1023];
  logic [7:0] din_q = 8'h00;

  always @(posedge clk) begin
    if (bus.mem_wr) ram[bus.mem_a[9:0]] <= bus.mem_dout;
    din_q <= ram[bus.mem_a[9:0]];
  end
  assign bus.mem_din = din_q;

  typedef struct { int port; bit err; bit chk; logic [31:0] rdata; int lat; } exp_t;
  typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;

  exp_t exp_q[$];
  wr_t  wq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every RAM write strobe must match the next queued byte.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.mem_wr === 1'b1) begin
      if (wq.size() == 0) begin
        check_eq("wr_spurious", 64'(bus.mem_wr), 64'd0);
      end else begin
        wr_t w;
        w = wq.pop_front();
        check_eq("wr_addr", 64'(bus.mem_a), 64'(w.a));
        check_eq("wr_data", 64'(bus.mem_dout), 64'(w.d));
      end
    end
  end

  task automatic push_exp(input int port, input bit wr, input logic [1:0] len,
                          input logic [31:0] addr, input logic [31:0] wdata, input int extra);
    exp_t e;
    wr_t  w;
    int   n;
    bit   rej;
    n   = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    rej = 1'b0;
`ifndef MEM_ARB_MISALIGN_EN
    rej = ((len == 2'b01) && addr[0]) || (len[1] && (addr[1:0] != 2'b00));
`endif
    e.port  = port;
    e.err   = rej;
    e.chk   = !wr || rej;
    e.rdata = '0;
    e.lat   = (rej ? 2 : (wr ? n + 2 : n + 3)) + extra;
    for (int i = 0; i < n; i++) begin
      if (!rej && !wr) e.rdata[8*i +: 8] = ram[10'(addr + 32'(i))];
      if (!rej && wr) begin
        w.a = addr + 32'(i);
        w.d = wdata[8*i +: 8];
        wq.push_back(w);
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic drive_req(input int port, input bit wr, input logic [1:0] len,
                           input logic [31:0] addr, input logic [31:0] wdata);
    bus.wr_in[port]                = wr;
    bus.len_in[2*port +: 2]        = len;
    bus.addr_in[AW*port +: AW]     = addr;
    bus.wdata_in[32*port +: 32]    = wdata;
    bus.req_in[port]               = 1'b1;
  endtask

  // Called just after a rising edge; cycle 1 is the current cycle.
  task automatic wait_done(input int stall_at, input int stall_len, output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 1;
    while (!ok && cyc <= 60) begin
      if (stall_len > 0 && cyc == stall_at) rdy = 1'b0;
      if (stall_len > 0 && cyc == stall_at + stall_len) rdy = 1'b1;
      @(negedge clk);
      if ((bus.done_out | bus.err_out) != '0) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    rdy = 1'b1;
  endtask

  task automatic check_done(input int cyc);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_eq("sb_unexpected", 64'(bus.done_out | bus.err_out), 64'd0);
      return;
    end
    e = exp_q.pop_front();
    check_eq("done_vec", 64'(bus.done_out), e.err ? 64'd0 : 64'(1 << e.port));
    check_eq("err_vec", 64'(bus.err_out), e.err ? 64'(1 << e.port) : 64'd0);
    if (e.chk) check_eq("rdata", 64'(bus.rdata_out), 64'(e.rdata));
    check_eq("latency", 64'(cyc), 64'(e.lat));
  endtask

  task automatic run_txn(input int port, input bit wr, input logic [1:0] len,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int stall_at, input int stall_len);
    bit ok;
    int cyc;
    push_exp(port, wr, len, addr, wdata, stall_len);
    drive_req(port, wr, len, addr, wdata);
    wait_done(stall_at, stall_len, ok, cyc);
    check_eq("timeout", 64'(ok), 64'd1);
    if (ok) check_done(cyc);
    bus.req_in = '0;
    @(posedge clk);
    #1;
    check_eq("bubble_grant", 64'(bus.grant_out), 64'd0);
    check_eq("wr_left", 64'(wq.size()), 64'd0);
    if (!ok) begin
      exp_q.delete();
      wq.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int cyc;
    for (int i = 0; i < 1024; i++) ram[i] = 8'(i * 7 + 3);
    rst_n        = 1'b0;
    rdy          = 1'b1;
    bus.req_in   = '0;
    bus.wr_in    = '0;
    bus.len_in   = '0;
    bus.addr_in  = '0;
    bus.wdata_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_grant", 64'(bus.grant_out), 64'd0);
    check_eq("rst_done",  64'(bus.done_out),  64'd0);
    check_eq("rst_err",   64'(bus.err_out),   64'd0);
    check_eq("rst_rdata", 64'(bus.rdata_out), 64'd0);
    check_eq("rst_mem_a", 64'(bus.mem_a),     64'd0);
    check_eq("rst_dout",  64'(bus.mem_dout),  64'd0);
    check_eq("rst_wr",    64'(bus.mem_wr),    64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic word write/read and narrow reads of the written word.
    run_txn(0, 1'b1, 2'b10, 32'h100, 32'h1122_3344, 0, 0);
    run_txn(0, 1'b0, 2'b10, 32'h100, 32'h0, 0, 0);
    run_txn(0, 1'b0, 2'b00, 32'h103, 32'h0, 0, 0);
    run_txn(1, 1'b0, 2'b01, 32'h102, 32'h0, 0, 0);
    run_txn(1, 1'b1, 2'b00, 32'h110, 32'h0000_00A5, 0, 0);
    run_txn(1, 1'b1, 2'b01, 32'h112, 32'h0000_BEEF, 0, 0);
    run_txn(0, 1'b0, 2'b10, 32'h110, 32'h0, 0, 0);
    run_txn(1, 1'b0, 2'b11, 32'h200, 32'h0, 0, 0);

    // Stalls: mid-write, mid-read, over the done cycle, and over the arbitration cycle.
    run_txn(0, 1'b1, 2'b10, 32'h120, 32'hCAFE_F00D, 3, 3);
    run_txn(0, 1'b0, 2'b10, 32'h120, 32'h0, 3, 3);
    run_txn(1, 1'b0, 2'b00, 32'h121, 32'h0, 4, 2);
    run_txn(0, 1'b0, 2'b01, 32'h122, 32'h0, 1, 2);

    // Misaligned accesses: rejected by default, sequenced byte-wise when enabled.
    run_txn(0, 1'b0, 2'b10, 32'h102, 32'h0, 0, 0);
    run_txn(1, 1'b0, 2'b01, 32'h101, 32'h0, 0, 0);
    run_txn(0, 1'b1, 2'b10, 32'h131, 32'h0102_0304, 0, 0);

    // Reset during a word write once byte 1 has gone out.
    push_exp(0, 1'b1, 2'b01, 32'h300, 32'hAABB_CCDD, 0);
    void'(exp_q.pop_back());
    drive_req(0, 1'b1, 2'b10, 32'h300, 32'hAABB_CCDD);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    bus.req_in = '0;
    check_eq("arst_grant", 64'(bus.grant_out), 64'd0);
    check_eq("arst_done",  64'(bus.done_out),  64'd0);
    check_eq("arst_wr",    64'(bus.mem_wr),    64'd0);
    check_eq("arst_mem_a", 64'(bus.mem_a),     64'd0);
    check_eq("arst_dout",  64'(bus.mem_dout),  64'd0);
    check_eq("arst_rdata", 64'(bus.rdata_out), 64'd0);
    check_eq("arst_wr_cnt", 64'(wq.size()),    64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("arst_no_done", 64'(bus.done_out), 64'd0);
    end
    @(posedge clk);
    #1;

    // Both ports hold word reads; rotation must start at port 0 after reset.
    bus.wr_in = '0;
    for (int k = 0; k < 4; k++)
      push_exp(k % 2, 1'b0, 2'b10, (k % 2 == 0) ? 32'h100 : 32'h200, 32'h0, 0);
    drive_req(0, 1'b0, 2'b10, 32'h100, 32'h0);
    drive_req(1, 1'b0, 2'b10, 32'h200, 32'h0);
    for (int k = 0; k < 4; k++) begin
      wait_done(0, 0, ok, cyc);
      check_eq("rr_timeout", 64'(ok), 64'd1);
      if (ok) check_done(cyc);
      if (k == 3) bus.req_in = '0;
      @(posedge clk);
      #1;
      check_eq("rr_bubble", 64'(bus.grant_out), 64'd0);
    end
    check_eq("sb_left", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
